// File: rtl/pacman_soc_key_pio.sv
// Key PIO for the Pac-Man SoC: an Avalon-MM slave that synchronizes and
// debounces WIDTH key inputs, latches the selected edges, and raises a
// maskable level interrupt.
//   addr 0 : debounced key state (RO)
//   addr 1 : reserved (reads 0, writes ignored)
//   addr 2 : irq_mask (RW)
//   addr 3 : edge_capture (RO, write 1 per bit clears)

// One key lane: a 2-flop synchronizer followed by a stability counter.
// The debounced bit follows the synchronized input only after it has
// differed for DEBOUNCE_CYCLES consecutive clocks. Any shorter excursion
// clears the counter and leaves the debounced bit untouched.
module pacman_soc_key_pio_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE            = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_i,
  output logic deb_o
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d;

  // Two-stage synchronizer; sync_q[1] is the metastability-safe copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{IDLE}};
    else          sync_q <= {sync_q[0], key_i};
  end

  // Count consecutive cycles where the synchronized input disagrees with
  // the debounced bit; flip the debounced bit on the last count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= IDLE;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

module pacman_soc_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam bit IDLE_BIT = (IDLE_LEVEL != 0);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } bus_req_t;

  bus_req_t         req;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_wdata;

  // Upper write data bits have no destination.
  assign unused_wdata = ^writedata;

  assign req.rd   = chipselect & ~read_n;
  assign req.wr   = chipselect & ~write_n;
  assign req.addr = address;

  // One independent synchronizer/debouncer per key.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pacman_soc_key_pio_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE            (IDLE_BIT)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .key_i   (in_port[i]),
      .deb_o   (deb[i])
    );
  end

  // Delayed copy of the debounced vector for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_dly_q <= {WIDTH{IDLE_BIT}};
    else          deb_dly_q <= deb;
  end

  // Select which transitions count as events.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = deb & ~deb_dly_q;
      1:       edge_det = ~deb & deb_dly_q;
      default: edge_det = deb ^ deb_dly_q;
    endcase
  end

  // Capture/mask next state. A new edge wins over a same-cycle clear so
  // that no event is lost to a software race.
  always_comb begin
    edge_clr = '0;
    mask_d   = mask_q;
    if (req.wr && req.addr == A_EDGE) edge_clr = writedata[WIDTH-1:0];
    if (req.wr && req.addr == A_MASK) mask_d   = writedata[WIDTH-1:0];
    ecap_d = (ecap_q & ~edge_clr) | edge_det;
  end

  // Capture and mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ecap_q <= '0;
      mask_q <= '0;
    end else begin
      ecap_q <= ecap_d;
      mask_q <= mask_d;
    end
  end

  // Read mux; uses current register values so a read racing a clear of
  // the capture register returns the pre-clear contents.
  always_comb begin
    rdata_d = '0;
    case (req.addr)
      A_DATA:  rdata_d[WIDTH-1:0] = deb;
      A_MASK:  rdata_d[WIDTH-1:0] = mask_q;
      A_EDGE:  rdata_d[WIDTH-1:0] = ecap_q;
      default: rdata_d = '0;
    endcase
  end

  // Read data is loaded only on a read strobe and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rdata_q <= '0;
    else if (req.rd) rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;
  assign irq      = |(ecap_q & mask_q);

endmodule

// File: doc/pacman_soc_key_pio.md
PACMAN_SOC_KEY_PIO -- requirements
Module: pacman_soc_key_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of key input bits (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a debounced bit changes (range 2..65535).
REQ-003 SHALL have parameter EDGE_TYPE, default 1: captured edge (0 rising, 1 falling, 2 any).
REQ-004 SHALL have parameter IDLE_LEVEL, default 1: reset value of the synchronizer and debounced bits (all ones or all zeros).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port address, input, 2: Avalon-MM slave word address.
REQ-008 SHALL have port chipselect, input, 1: slave select.
REQ-009 SHALL have port read_n, input, 1: read strobe, active-low.
REQ-010 SHALL have port write_n, input, 1: write strobe, active-low.
REQ-011 SHALL have port writedata, input, 32: write data.
REQ-012 SHALL have port in_port, input, WIDTH: asynchronous key inputs.
REQ-013 SHALL have port readdata, output, 32: registered read data; bits above WIDTH read 0.
REQ-014 SHALL have port irq, output, 1: level interrupt, active-high.

Function
REQ-015 SHALL pass in_port through a 2-flop synchronizer per bit; sync value is valid 2 clocks after an input change.
REQ-016 SHALL debounce each bit independently: a 16-bit counter increments while sync != debounced and clears to 0 whenever sync == debounced.
REQ-017 SHALL update debounced[i] <= sync[i] and clear its counter on the clock where counter == DEBOUNCE_CYCLES-1 and sync != debounced, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-018 SHALL keep debounced[i] unchanged on any glitch shorter than DEBOUNCE_CYCLES cycles; the counter restarts from 0.
REQ-019 SHALL register debounced into debounced_d each clock and detect edges as debounced & ~debounced_d (rising) or ~debounced & debounced_d (falling), per EDGE_TYPE.
REQ-020 SHALL set edge_capture[i] on the clock after the detected edge; the bit stays set until cleared by software.
REQ-021 SHALL implement the register map: addr 0 data (RO, debounced); addr 1 reserved (reads 0, writes ignored); addr 2 irq_mask (RW, WIDTH bits); addr 3 edge_capture (read; write 1 per bit clears).
REQ-022 SHALL treat a write as chipselect & ~write_n, and a read as chipselect & ~read_n.
REQ-023 SHALL return readdata with read latency 1: readdata is registered on the clock of the read strobe and holds its value until the next read.
REQ-024 SHALL give set priority over clear: an edge and a write-1-to-clear on the same bit in the same cycle leave the bit set.
REQ-025 SHALL drive irq = |(edge_capture & irq_mask), combinationally from registers, with no extra latency.
REQ-026 SHALL apply a mask write on the next clock; an irq for a bit that is already captured asserts immediately after unmasking.
REQ-027 SHALL return the pre-clear edge_capture value when a read and a clear of addr 3 occur in the same cycle.

Reset
REQ-028 SHALL, on reset_n low, immediately set sync, debounced and debounced_d to IDLE_LEVEL; set counters, edge_capture, irq_mask and readdata to 0; and force irq to 0.
REQ-029 SHALL abort any in-progress debounce on reset; no edge SHALL be captured after reset release while in_port remains at IDLE_LEVEL.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=1, IDLE_LEVEL=1)
REQ-030 SHALL cover: in_port 4'hF->4'hE held -> data read 0xE; edge_capture bit0 set at cycle 2+4+1 after the input change; irq=0 while mask is 0.
REQ-031 SHALL cover: bit0 low pulse of 3 cycles -> data stays 0xF; edge_capture stays 0.
REQ-032 SHALL cover: mask write 0x1, then a bit0 falling edge -> irq=1; write 0x1 to addr 3 -> irq=0 on the next clock; reading addr 3 then returns 0.
REQ-033 SHALL cover: a write-1-to-clear of bit0 in the same cycle as a new bit0 edge -> bit0 remains 1.
REQ-034 SHALL cover: reset_n asserted mid-debounce with edge_capture=0x3 and mask=0xF -> irq=0 immediately; after release all registers read 0, data reads 0xF, and no edge is captured with idle inputs.
REQ-035 SHALL cover: read of addr 1 -> 0; write to addr 0 -> ignored, data unchanged.
